// File: rtl/ov7670_pkg.sv
// ov7670_pkg: shared state encoding and reserved ROM codes for the OV7670 SCCB configurator.
package ov7670_pkg;
  typedef enum logic [3:0] {IDLE, FETCH, DECODE, START, BYTE, STOP, GAP, DELAY, DONE} sccb_state_t;
  localparam logic [15:0] SCCB_END = 16'hFFFF;
  localparam logic [15:0] SCCB_DELAY = 16'hFFF0;
  localparam logic [7:0] OV7670_ID = 8'h42;
endpackage

// File: rtl/sccb_quarter_tick.sv
// sccb_quarter_tick: one-cycle tick every QTR cycles, realigned by restart_i.
module sccb_quarter_tick #(
  parameter int QTR = 250
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic restart_i,
  output logic tick_o
);
  localparam int W = QTR > 1 ? $clog2(QTR) : 1;
  logic [W-1:0] cnt;
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt <= W'(QTR - 1);
      tick_o <= 1'b0;
    end else begin
      tick_o <= !restart_i && cnt == '0;
      cnt <= restart_i || cnt == '0 ? W'(QTR - 1) : cnt - W'(1);
    end
  end
endmodule

// File: rtl/ov7670_sccb_config.sv
// ov7670_sccb_config: walks the OV7670 config ROM and writes each entry as a 3-phase SCCB write.
// Define SCCB_ACK_CHECK_EN to sample the 9th bit of each phase and abort with error_o on NACK.
module ov7670_sccb_config
  import ov7670_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int SCCB_FREQ_HZ = 100_000,
  parameter logic [7:0] DEVICE_ID = OV7670_ID,
  parameter int DELAY_CYCLES = 1_000_000,
  parameter int ROM_AW = 8
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              start_i,
  output logic [ROM_AW-1:0] rom_addr_o,
  input  logic [15:0]       rom_data_i,
  output logic              sioc_o,
  output logic              siod_o,
  output logic              siod_oe_o,
  input  logic              siod_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o
);
  localparam int QTR = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
  localparam int DW = $clog2(DELAY_CYCLES + 1);
  sccb_state_t state, state_d;
  logic [1:0] q, q_d, phase, phase_d;
  logic [3:0] bit_cnt, bit_d;
  logic [7:0] sh, sh_d;
  logic [15:0] ent, ent_d;
  logic [DW-1:0] dly, dly_d;
  logic [ROM_AW-1:0] addr_d;
  logic busy_d, done_d, err_d, sioc_d, siod_d, oe_d;
  logic tick, restart, adv, at_end, nack;

`ifdef SCCB_ACK_CHECK_EN
  assign nack = siod_i;
`else
  logic unused_siod;
  assign unused_siod = siod_i;
  assign nack = 1'b0;
`endif

  sccb_quarter_tick #(.QTR(QTR)) u_tick (
    .clk_i(clk_i),
    .reset_ni(reset_ni),
    .restart_i(restart),
    .tick_o(tick)
  );

  assign at_end = rom_addr_o == {ROM_AW{1'b1}};

  always_comb begin
    state_d = state;
    q_d = q;
    bit_d = bit_cnt;
    phase_d = phase;
    sh_d = sh;
    ent_d = ent;
    dly_d = dly;
    addr_d = rom_addr_o;
    busy_d = busy_o;
    done_d = done_o;
    err_d = error_o;
    restart = 1'b0;
    adv = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_d = start_i ? FETCH : IDLE;
        if (start_i) begin
          addr_d = '0;
          busy_d = 1'b1;
          done_d = 1'b0;
          err_d = 1'b0;
        end
      end
      FETCH: state_d = DECODE;
      DECODE: begin
        state_d = rom_data_i == SCCB_END ? DONE : rom_data_i == SCCB_DELAY ? DELAY : START;
        dly_d = DW'(DELAY_CYCLES - 1);
        ent_d = rom_data_i;
        q_d = '0;
        restart = state_d == START;
      end
      START: if (tick) begin
        q_d = q == 2'd2 ? 2'd0 : q + 2'd1;
        if (q == 2'd2) begin
          state_d = BYTE;
          bit_d = '0;
          phase_d = '0;
          sh_d = DEVICE_ID;
        end
      end
      BYTE: if (tick) begin
        q_d = q + 2'd1;
        // the 9th bit is sampled mid-high, at the Q2->Q3 boundary
        if (q == 2'd2 && bit_cnt == 4'd8 && nack) err_d = 1'b1;
        if (q == 2'd3) begin
          bit_d = bit_cnt == 4'd8 ? 4'd0 : bit_cnt + 4'd1;
          phase_d = bit_cnt == 4'd8 ? phase + 2'd1 : phase;
          sh_d = bit_cnt != 4'd8 ? {sh[6:0], 1'b0} : phase == 2'd0 ? ent[15:8] : ent[7:0];
          if (bit_cnt == 4'd8 && (phase == 2'd2 || error_o)) state_d = STOP;
        end
      end
      STOP: if (tick) begin
        q_d = q == 2'd2 ? 2'd0 : q + 2'd1;
        if (q == 2'd2) state_d = error_o ? DONE : GAP;
      end
      GAP: if (tick) begin
        q_d = q + 2'd1;
        adv = q == 2'd3;
      end
      DELAY: begin
        dly_d = dly - DW'(1);
        adv = dly == '0;
      end
      default: state_d = IDLE;
    endcase
    // the last ROM slot finishes the list instead of wrapping to 0
    if (adv) begin
      state_d = at_end ? DONE : FETCH;
      addr_d = rom_addr_o + ROM_AW'(!at_end);
    end
    if (state_d == DONE) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end
    sioc_d = state_d == BYTE ? q_d[1] : state_d == START ? q_d != 2'd2 : state_d == STOP ? q_d != 2'd0 : 1'b1;
    siod_d = state_d == BYTE ? bit_d == 4'd8 || sh_d[7] : state_d == START ? q_d == 2'd0 : state_d == STOP ? q_d == 2'd2 : 1'b1;
    oe_d = !(state_d == BYTE && bit_d == 4'd8);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state <= IDLE;
      q <= '0;
      bit_cnt <= '0;
      phase <= '0;
      sh <= '0;
      ent <= '0;
      dly <= '0;
      rom_addr_o <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      error_o <= 1'b0;
      sioc_o <= 1'b1;
      siod_o <= 1'b1;
      siod_oe_o <= 1'b1;
    end else begin
      state <= state_d;
      q <= q_d;
      bit_cnt <= bit_d;
      phase <= phase_d;
      sh <= sh_d;
      ent <= ent_d;
      dly <= dly_d;
      rom_addr_o <= addr_d;
      busy_o <= busy_d;
      done_o <= done_d;
      error_o <= err_d;
      sioc_o <= sioc_d;
      siod_o <= siod_d;
      siod_oe_o <= oe_d;
    end
  end
endmodule

// File: tb/tb_ov7670_sccb_config.sv
// tb_ov7670_sccb_config: bus-level monitor against a ROM-walk reference model, with randomized ROM contents.
module tb_ov7670_sccb_config;
  localparam int QTR = 10, DLY = 500, AW = 3, N = 8;
  logic clk = 1'b0, reset_ni = 1'b1, start_i = 1'b0, ack_level = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [15:0] rom_data = '0;
  logic sioc, siod, siod_oe, busy, done, error;
  wire siod_i;
  logic [15:0] rom [N];
  int cyc = 0, t0 = 0, done_cyc = 0, n_tests = 0, n_fail = 0;
  int starts, stops, nbits, oe_err, idle_low, first_fall, last_stop, min_gap, max_gap;
  int exp_nd, exp_addr;
  bit in_tx = 0;
  logic psioc = 1'b1, psiod = 1'b1;
  logic [23:0] acc;
  logic [23:0] got_q[$], exp_q[$];

  ov7670_sccb_config #(
    .CLK_FREQ_HZ(4 * QTR * 10), .SCCB_FREQ_HZ(10), .DEVICE_ID(8'h42),
    .DELAY_CYCLES(DLY), .ROM_AW(AW)
  ) dut (
    .clk_i(clk), .reset_ni(reset_ni), .start_i(start_i), .rom_addr_o(rom_addr),
    .rom_data_i(rom_data), .sioc_o(sioc), .siod_o(siod), .siod_oe_o(siod_oe),
    .siod_i(siod_i), .busy_o(busy), .done_o(done), .error_o(error)
  );

  assign siod_i = siod_oe ? siod : ack_level;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) rom_data <= rom[rom_addr];

  // reconstruct START/bytes/STOP from the pins alone
  always @(negedge clk) begin
    if (!reset_ni) begin
      in_tx = 0;
      nbits = 0;
      psioc = 1'b1;
      psiod = 1'b1;
    end else begin
      if (psioc && sioc && psiod && !siod) begin
        starts++;
        in_tx = 1;
        nbits = 0;
        acc = '0;
        if (first_fall < 0) first_fall = cyc;
        if (last_stop >= 0) begin
          if (cyc - last_stop < min_gap) min_gap = cyc - last_stop;
          if (cyc - last_stop > max_gap) max_gap = cyc - last_stop;
        end
      end else if (psioc && sioc && !psiod && siod) begin
        stops++;
        if (in_tx && nbits == 28) got_q.push_back(acc);
        in_tx = 0;
        last_stop = cyc;
      end else if (!psioc && sioc && in_tx) begin
        if (nbits < 27) begin
          if (nbits % 9 == 8) begin
            if (siod_oe) oe_err++;
          end else begin
            acc = {acc[22:0], siod};
            if (!siod_oe) oe_err++;
          end
        end
        nbits++;
      end
      if (!in_tx && !sioc) idle_low++;
      psioc = sioc;
      psiod = siod;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void build_exp();
    exp_q.delete();
    exp_nd = 0;
    exp_addr = N - 1;
    for (int a = 0; a < N; a++) begin
      if (rom[a] == 16'hFFFF) begin
        exp_addr = a;
        break;
      end
      if (rom[a] == 16'hFFF0) exp_nd++;
      else exp_q.push_back({8'h42, rom[a]});
    end
  endfunction

  function automatic logic [15:0] rnd_wr();
    logic [15:0] v;
    do v = 16'($urandom); while (v == 16'hFFFF || v == 16'hFFF0);
    return v;
  endfunction

  task automatic run(input int budget, input int poke);
    int n = 0;
    @(posedge clk);
    #1;
    got_q.delete();
    starts = 0; stops = 0; oe_err = 0; idle_low = 0;
    first_fall = -1; last_stop = -1; min_gap = 1 << 30; max_gap = 0;
    build_exp();
    @(negedge clk);
    check("busy_idle", busy, 0);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("busy_lat", busy, 1);
    check("done_clr", done, 0);
    t0 = cyc;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
      start_i = n == poke && !done;
    end
    start_i = 1'b0;
    done_cyc = cyc;
    check("done_seen", done, 1);
  endtask

  task automatic check_result(input string tag);
    int nw = exp_q.size();
    check({tag, "_ntx"}, got_q.size(), nw);
    foreach (exp_q[i]) check({tag, "_tx"}, i < got_q.size() ? got_q[i] : 24'h0, exp_q[i]);
    check({tag, "_starts"}, starts, nw);
    check({tag, "_stops"}, stops, nw);
    check({tag, "_oe"}, oe_err, 0);
    check({tag, "_idle_low"}, idle_low, 0);
    check({tag, "_addr"}, rom_addr, exp_addr);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_tmin"}, done_cyc - t0 >= nw * 117 * QTR + exp_nd * DLY, 1);
    check({tag, "_tmax"}, done_cyc - t0 <= nw * (118 * QTR + 4) + exp_nd * (DLY + 4) + 4, 1);
    if (nw >= 2) check({tag, "_gap"}, min_gap >= 4 * QTR, 1);
  endtask

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, idx;
    rom = '{16'h1280, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    #2 reset_ni = 1'b0;
    #1;
    check("rst_sioc", sioc, 1);
    check("rst_siod", siod, 1);
    check("rst_oe", siod_oe, 1);
    check("rst_addr", rom_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    repeat (3) @(negedge clk);
    reset_ni = 1'b1;

    run(20000, 0);
    check_result("single");
    check("first_fall", first_fall - t0, 3 + QTR);
    repeat (5) @(negedge clk);
    check("done_sticky", done, 1);

    rom = '{16'h1180, 16'h3a04, 16'h40d0, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0};
    run(20000, 1500);
    check_result("multi");

    rom = '{16'h1280, 16'hFFF0, 16'h1180, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0};
    run(20000, 0);
    check_result("delay");
    check("delay_gap", max_gap >= DLY, 1);

    for (int it = 0; it < 4; it++) begin
      idx = 0;
      foreach (rom[a]) rom[a] = 16'($urandom);
      for (int w = $urandom_range(1, 3); w > 0; w--) begin
        if ($urandom_range(0, 3) == 0) rom[idx++] = 16'hFFF0;
        rom[idx++] = rnd_wr();
      end
      rom[idx] = 16'hFFFF;
`ifndef SCCB_ACK_CHECK_EN
      ack_level = 1'($urandom_range(0, 1));
`endif
      run(30000, $urandom_range(0, 1) ? $urandom_range(50, 2000) : 0);
      check_result("rand");
    end
    ack_level = 1'b0;

    foreach (rom[a]) rom[a] = rnd_wr();
    run(20000, 0);
    check_result("wrap");

    rom = '{16'h1280, 16'h3a04, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    n = 0;
    while (!(in_tx && nbits >= 10) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("rst_reach_reg", in_tx && nbits >= 10, 1);
    #2 reset_ni = 1'b0;
    #1;
    check("rst_mid_sioc", sioc, 1);
    check("rst_mid_siod", siod, 1);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_addr", rom_addr, 0);
    repeat (2) @(negedge clk);
    reset_ni = 1'b1;
    run(20000, 0);
    check_result("restart");

    rom = '{16'h1280, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    ack_level = 1'b1;
    run(20000, 0);
`ifdef SCCB_ACK_CHECK_EN
    check("nack_error", error, 1);
    check("nack_addr", rom_addr, 0);
    check("nack_stops", stops, 1);
    check("nack_starts", starts, 1);
    check("nack_ntx", got_q.size(), 0);
    check("nack_busy", busy, 0);
    ack_level = 1'b0;
    run(20000, 0);
    check_result("after_nack");
`else
    check_result("nack_ignored");
    ack_level = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
